// File: rtl/stream_pkg.sv
// Shared constants for the stream demux: buffer occupancy encoding
// and destination select encoding.
package stream_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam logic DEST_OUT0 = 1'b0;
    localparam logic DEST_OUT1 = 1'b1;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO decoupling one demux output from its consumer.
// Ports: clk, rst (sync, active-high); push/data_in/full on the write
// side; pop (consumer ready)/data_out/valid on the read side.
module skid_fifo2
    import stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       occ;
    logic             do_push;
    logic             do_pop;

    assign full     = (occ == OCC_FULL);
    assign valid    = (occ != OCC_EMPTY);
    assign data_out = mem[rd_ptr];

    // pop is the consumer's ready; only an actual handshake pops.
    assign do_push  = push & ~full;
    assign do_pop   = pop & valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= OCC_EMPTY;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // push+pop together leaves occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux12.sv
// 1-to-2 valid/ready stream demultiplexer with a 2-entry buffer per output.
// Ports: clk, rst; in_data/in_sel/in_valid/in_ready input stream;
// outS_data/outS_valid/outS_ready per output; cntS delivered-beat counters.
module stream_demux12
    import stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0;
    logic full1;
    logic fire;
    logic push0;
    logic push1;

    // Ready comes from registered occupancy only, so consumer ready
    // never reaches in_ready combinationally.
    assign in_ready = (in_sel == DEST_OUT1) ? ~full1 : ~full0;
    assign fire     = in_valid & in_ready;
    assign push0    = fire & (in_sel == DEST_OUT0);
    assign push1    = fire & (in_sel == DEST_OUT1);

    skid_fifo2 #(.WIDTH(WIDTH)) u_buf0 (
        .clk      (clk),
        .rst      (rst),
        .push     (push0),
        .data_in  (in_data),
        .full     (full0),
        .pop      (out0_ready),
        .data_out (out0_data),
        .valid    (out0_valid)
    );

    skid_fifo2 #(.WIDTH(WIDTH)) u_buf1 (
        .clk      (clk),
        .rst      (rst),
        .push     (push1),
        .data_in  (in_data),
        .full     (full1),
        .pop      (out1_ready),
        .data_out (out1_data),
        .valid    (out1_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (out1_valid && out1_ready) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule
